// File: rtl/lvt_write_scheduler_if.sv
// Write-request and write-issue bundle between the port clients, the scheduler
// and lvt_memory / bank RAMs.
interface lvt_write_scheduler_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512,
   parameter int PORTS = 16
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              req_valid [PORTS];
   logic              req_ready [PORTS];
   logic [ADDR_W-1:0] req_addr  [PORTS];
   logic [WIDTH-1:0]  req_data  [PORTS];
   logic              hold;
   logic              wr_en     [PORTS];
   logic [ADDR_W-1:0] wr_addr   [PORTS];
   logic [WIDTH-1:0]  wr_data   [PORTS];
   logic [31:0]       conflict_count;
   logic              busy;

   modport master (
      output req_valid, req_addr, req_data, hold,
      input  req_ready, wr_en, wr_addr, wr_data, conflict_count, busy
   );

   modport slave (
      input  req_valid, req_addr, req_data, hold,
      output req_ready, wr_en, wr_addr, wr_data, conflict_count, busy
   );
endinterface

// File: rtl/lvt_write_scheduler.sv
// Per-port write FIFOs with lowest-index-wins same-address arbitration, feeding
// registered collision-free write vectors to lvt_memory and its bank RAMs.
module lvt_write_scheduler #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 512,
   parameter int PORTS      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input logic                 clk,
   input logic                 rst,
   lvt_write_scheduler_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int NST_W  = $clog2(PORTS + 1);

   logic [ADDR_W-1:0] fifo_addr [PORTS][FIFO_DEPTH];
   logic [WIDTH-1:0]  fifo_data [PORTS][FIFO_DEPTH];
   logic [PTR_W:0]    wptr    [PORTS];
   logic [PTR_W:0]    rptr    [PORTS];
   logic [PTR_W:0]    wptr_p1 [PORTS];

   logic              ready     [PORTS];
   logic              push      [PORTS];
   logic              cand      [PORTS];
   logic              win       [PORTS];
   logic [ADDR_W-1:0] head_addr [PORTS];
   logic [WIDTH-1:0]  head_data [PORTS];
   logic [NST_W-1:0]  n_stall;
   logic              busy;

   logic              en_p1   [PORTS];
   logic [ADDR_W-1:0] addr_p1 [PORTS];
   logic [WIDTH-1:0]  data_p1 [PORTS];
   logic [31:0]       conflict_cnt;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [NST_W-1:0] b);
      logic [32:0] s;
      s = {1'b0, a} + 33'(b);
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   always_comb begin
      n_stall = '0;
      busy    = 1'b0;
      for (int p = 0; p < PORTS; p++) begin
         ready[p]     = !((wptr[p][PTR_W] != rptr[p][PTR_W]) &&
                          (wptr[p][PTR_W-1:0] == rptr[p][PTR_W-1:0])) && !rst;
         push[p]      = bus.req_valid[p] && ready[p];
         head_addr[p] = fifo_addr[p][rptr[p][PTR_W-1:0]];
         head_data[p] = fifo_data[p][rptr[p][PTR_W-1:0]];
         // Delayed write pointer: a new entry becomes head-eligible one cycle after its push.
         cand[p]      = (wptr_p1[p] != rptr[p]) && !bus.hold;
         busy         = busy || (wptr[p] != rptr[p]) || en_p1[p];
      end
      for (int p = 0; p < PORTS; p++) begin
         win[p] = cand[p];
         for (int q = 0; q < p; q++) begin
            if (cand[q] && (head_addr[q] == head_addr[p])) win[p] = 1'b0;
         end
         n_stall = n_stall + NST_W'(cand[p] && !win[p]);
      end
   end

   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         bus.req_ready[p] = ready[p];
         bus.wr_en[p]     = en_p1[p];
         bus.wr_addr[p]   = addr_p1[p];
         bus.wr_data[p]   = data_p1[p];
      end
      bus.conflict_count = conflict_cnt;
      bus.busy           = busy;
   end

   // FIFO storage: data only, no reset
   always_ff @(posedge clk) begin
      for (int p = 0; p < PORTS; p++) begin
         if (push[p]) begin
            fifo_addr[p][wptr[p][PTR_W-1:0]] <= bus.req_addr[p];
            fifo_data[p][wptr[p][PTR_W-1:0]] <= bus.req_data[p];
         end
      end
   end

   // Pointers, issue register (_p1) and collision counter
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < PORTS; p++) begin
            wptr[p]    <= '0;
            rptr[p]    <= '0;
            wptr_p1[p] <= '0;
            en_p1[p]   <= 1'b0;
            addr_p1[p] <= '0;
            data_p1[p] <= '0;
         end
         conflict_cnt <= '0;
      end else begin
         for (int p = 0; p < PORTS; p++) begin
            wptr_p1[p] <= wptr[p];
            if (push[p]) wptr[p] <= wptr[p] + (PTR_W+1)'(1);
            if (win[p]) begin
               rptr[p]    <= rptr[p] + (PTR_W+1)'(1);
               addr_p1[p] <= head_addr[p];
               data_p1[p] <= head_data[p];
            end
            en_p1[p] <= win[p];
         end
         conflict_cnt <= sat_add(conflict_cnt, n_stall);
      end
   end
endmodule

// File: tb/tb_lvt_write_scheduler.sv
// Directed bench for lvt_write_scheduler: vector table for latency/collision,
// plus sequences for hold/backpressure, streaming, reset and counter saturation.
module tb_lvt_write_scheduler;
   localparam int P  = 4;
   localparam int AW = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   lvt_write_scheduler_if #(.WIDTH(32), .DEPTH(512), .PORTS(P)) bus ();

   lvt_write_scheduler #(.WIDTH(32), .DEPTH(512), .PORTS(P), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [3:0]    v;
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          hold;
      logic [3:0]    en;
      logic [AW-1:0] eaddr;
      logic [31:0]   edata;
      logic [31:0]   cnt;
      logic          busy;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] en_mask();
      logic [3:0] m;
      for (int p = 0; p < P; p++) m[p] = bus.wr_en[p];
      return m;
   endfunction

   function automatic logic [3:0] rdy_mask();
      logic [3:0] m;
      for (int p = 0; p < P; p++) m[p] = bus.req_ready[p];
      return m;
   endfunction

   task automatic idle();
      for (int p = 0; p < P; p++) begin
         bus.req_valid[p] = 1'b0;
         bus.req_addr[p]  = '0;
         bus.req_data[p]  = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{4'b0001, 9'h010, 32'hA5A5_0001, 1'b0, 4'b0000, 9'h000, 32'h0,          32'd0, 1'b1};
      tbl[1]  = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b0000, 9'h000, 32'h0,          32'd0, 1'b1};
      tbl[2]  = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b0001, 9'h010, 32'hA5A5_0001, 32'd0, 1'b1};
      tbl[3]  = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b0000, 9'h000, 32'h0,          32'd0, 1'b0};
      tbl[4]  = '{4'b1111, 9'h100, 32'hB000_0000, 1'b0, 4'b0000, 9'h000, 32'h0,          32'd0, 1'b1};
      tbl[5]  = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b0000, 9'h000, 32'h0,          32'd0, 1'b1};
      tbl[6]  = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b0001, 9'h100, 32'hB000_0000, 32'd3, 1'b1};
      tbl[7]  = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b0010, 9'h100, 32'hB000_0000, 32'd5, 1'b1};
      tbl[8]  = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b0100, 9'h100, 32'hB000_0000, 32'd6, 1'b1};
      tbl[9]  = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b1000, 9'h100, 32'hB000_0000, 32'd6, 1'b1};
      tbl[10] = '{4'b0000, 9'h000, 32'h0,         1'b0, 4'b0000, 9'h000, 32'h0,          32'd6, 1'b0};

      // Reset state
      idle();
      bus.hold = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_ready", 32'(rdy_mask()), 32'h0);
      chk("rst_en", 32'(en_mask()), 32'h0);
      chk("rst_cnt", bus.conflict_count, 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_addr0", 32'(bus.wr_addr[0]), 32'h0);
      chk("rst_data0", bus.wr_data[0], 32'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(rdy_mask()), 32'hF);

      // Single write latency and four-way same-address collision
      for (int i = 0; i < 11; i++) begin
         for (int p = 0; p < P; p++) begin
            bus.req_valid[p] = tbl[i].v[p];
            bus.req_addr[p]  = tbl[i].addr;
            bus.req_data[p]  = tbl[i].data + 32'(p);
         end
         bus.hold = tbl[i].hold;
         tick();
         chk($sformatf("vec%0d_en", i), 32'(en_mask()), 32'(tbl[i].en));
         chk($sformatf("vec%0d_cnt", i), bus.conflict_count, tbl[i].cnt);
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
         for (int p = 0; p < P; p++) begin
            if (tbl[i].en[p]) begin
               chk($sformatf("vec%0d_addr%0d", i, p), 32'(bus.wr_addr[p]), 32'(tbl[i].eaddr));
               chk($sformatf("vec%0d_data%0d", i, p), bus.wr_data[p], tbl[i].edata + 32'(p));
            end
         end
      end
      chk("held_addr0", 32'(bus.wr_addr[0]), 32'h100);
      chk("held_data3", bus.wr_data[3], 32'hB000_0003);

      // Port 2 fills under hold, then drains in order
      idle();
      bus.hold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("hold_ready%0d", i), 32'(bus.req_ready[2]), (i < 4) ? 32'd1 : 32'd0);
         bus.req_valid[2] = 1'b1;
         bus.req_addr[2]  = 9'h020 + 9'(i);
         bus.req_data[2]  = 32'hC000_0000 + 32'(i);
         tick();
         chk($sformatf("hold_en%0d", i), 32'(en_mask()), 32'h0);
      end
      idle();
      tick();
      chk("hold_en_idle", 32'(en_mask()), 32'h0);
      chk("hold_cnt", bus.conflict_count, 32'd6);
      chk("hold_full", 32'(bus.req_ready[2]), 32'd0);
      bus.hold = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("drain%0d_en", k), 32'(en_mask()), 32'b0100);
         chk($sformatf("drain%0d_addr", k), 32'(bus.wr_addr[2]), 32'h020 + 32'(k));
         chk($sformatf("drain%0d_data", k), bus.wr_data[2], 32'hC000_0000 + 32'(k));
      end
      chk("drain_ready", 32'(bus.req_ready[2]), 32'd1);
      tick();
      chk("drain_done_en", 32'(en_mask()), 32'h0);
      chk("drain_done_busy", 32'(bus.busy), 32'h0);

      // Streaming: distinct addresses on every port, full throughput
      for (int c = 0; c < 23; c++) begin
         for (int p = 0; p < P; p++) begin
            bus.req_valid[p] = (c < 20);
            bus.req_addr[p]  = 9'(p);
            bus.req_data[p]  = 32'hD000_0000 + 32'(c * 16 + p);
         end
         tick();
         if (c >= 2 && c < 22) begin
            chk($sformatf("stream%0d_en", c), 32'(en_mask()), 32'hF);
            for (int p = 0; p < P; p++)
               chk($sformatf("stream%0d_data%0d", c, p), bus.wr_data[p],
                   32'hD000_0000 + 32'((c - 2) * 16 + p));
         end else begin
            chk($sformatf("stream%0d_en", c), 32'(en_mask()), 32'h0);
         end
      end
      chk("stream_cnt", bus.conflict_count, 32'd6);

      // Mid-operation reset discards queued writes
      bus.hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < P; p++) begin
            bus.req_valid[p] = 1'b1;
            bus.req_addr[p]  = 9'h040 + 9'(k * 4 + p);
            bus.req_data[p]  = 32'hE000_0000 + 32'(k * 4 + p);
         end
         tick();
      end
      idle();
      bus.hold = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(rdy_mask()), 32'h0);
      tick();
      rst = 1'b0;
      chk("midrst_en", 32'(en_mask()), 32'h0);
      chk("midrst_busy", 32'(bus.busy), 32'h0);
      chk("midrst_cnt", bus.conflict_count, 32'h0);
      tick();
      chk("postrst_en", 32'(en_mask()), 32'h0);
      bus.req_valid[1] = 1'b1;
      bus.req_addr[1]  = 9'h055;
      bus.req_data[1]  = 32'h1234_5678;
      tick();
      idle();
      chk("fresh_t0_en", 32'(en_mask()), 32'h0);
      tick();
      chk("fresh_t1_en", 32'(en_mask()), 32'h0);
      tick();
      chk("fresh_t2_en", 32'(en_mask()), 32'b0010);
      chk("fresh_addr", 32'(bus.wr_addr[1]), 32'h055);
      chk("fresh_data", bus.wr_data[1], 32'h1234_5678);

      // Counter saturation
      force dut.conflict_cnt = 32'hFFFF_FFFE;
      tick();
      release dut.conflict_cnt;
      #1;
      chk("preload_cnt", bus.conflict_count, 32'hFFFF_FFFE);
      for (int r = 0; r < 3; r++) begin
         bus.req_valid[0] = 1'b1;
         bus.req_valid[1] = 1'b1;
         bus.req_addr[0]  = 9'h0A0 + 9'(r);
         bus.req_addr[1]  = 9'h0A0 + 9'(r);
         tick();
         idle();
         tick();
         tick();
         chk($sformatf("sat%0d_cnt", r), bus.conflict_count, 32'hFFFF_FFFF);
         chk($sformatf("sat%0d_en_a", r), 32'(en_mask()), 32'b0001);
         tick();
         chk($sformatf("sat%0d_en_b", r), 32'(en_mask()), 32'b0010);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
